// File: rtl/esp_uart_if.sv
// Register-bus interface for esp_uart: word-addressed single-cycle read and write strobes.
interface esp_uart_if;
   logic [1:0]  bus_addr;
   logic [31:0] bus_wrdata;
   logic        bus_wren;
   logic        bus_rden;
   logic [31:0] bus_rddata;

   modport master (output bus_addr, bus_wrdata, bus_wren, bus_rden, input bus_rddata);
   modport slave  (input bus_addr, bus_wrdata, bus_wren, bus_rden, output bus_rddata);
endinterface

// File: rtl/esp_uart.sv
// esp_uart: 8N1 UART with RX/TX FIFOs behind a 4-word register bus (STATUS, DATA, CTRL).
// Define ESP_UART_HWFLOW_EN to build in CTS/RTS hardware flow control (CTRL bit0).
module esp_uart #(
   parameter int BAUD_DIV   = 25,
   parameter int FIFO_DEPTH = 16
) (
   input  logic      clk,
   input  logic      reset,
   esp_uart_if.slave cpu,
   output logic      uart_txd,
   input  logic      uart_rxd,
   input  logic      uart_cts_n,
   output logic      uart_rts_n
);
   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [15:0] BIT_END  = 16'(BAUD_DIV - 1);
   localparam logic [15:0] HALF_END = 16'(BAUD_DIV / 2 - 1);
   localparam logic [1:0]  IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

   logic [1:0] rxd_sync_reg, cts_sync_reg;
   logic       rxd_prev_reg, rxd_s;
   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_sync_reg <= 2'b11;
         cts_sync_reg <= 2'b11;
         rxd_prev_reg <= 1'b1;
      end else begin
         rxd_sync_reg <= {rxd_sync_reg[0], uart_rxd};
         cts_sync_reg <= {cts_sync_reg[0], uart_cts_n};
         rxd_prev_reg <= rxd_sync_reg[1];
      end
   end
   assign rxd_s = rxd_sync_reg[1];

   logic wr_status, wr_data, wr_ctrl, rd_data, flush, clr_ovf, clr_fe;
   assign wr_status = cpu.bus_wren && (cpu.bus_addr == 2'd0);
   assign wr_data   = cpu.bus_wren && (cpu.bus_addr == 2'd1);
   assign wr_ctrl   = cpu.bus_wren && (cpu.bus_addr == 2'd2);
   assign rd_data   = cpu.bus_rden && (cpu.bus_addr == 2'd1);
   assign flush     = wr_status && cpu.bus_wrdata[7];
   assign clr_ovf   = wr_status && cpu.bus_wrdata[2];
   assign clr_fe    = wr_status && cpu.bus_wrdata[3];

   logic [AW:0] rx_count_reg, tx_count_reg;
   logic        ctrl_flow, cts_ok;
`ifdef ESP_UART_HWFLOW_EN
   logic        ctrl_flow_reg;
   logic [AW:0] rx_free;
   always_ff @(posedge clk) begin
      if (reset)        ctrl_flow_reg <= 1'b0;
      else if (wr_ctrl) ctrl_flow_reg <= cpu.bus_wrdata[0];
   end
   assign ctrl_flow  = ctrl_flow_reg;
   assign cts_ok     = !(ctrl_flow_reg && cts_sync_reg[1]);
   assign rx_free    = FULL_CNT - rx_count_reg;
   assign uart_rts_n = ctrl_flow_reg && (rx_free < (AW+1)'(2));
`else
   assign ctrl_flow  = 1'b0;
   assign cts_ok     = 1'b1;
   assign uart_rts_n = 1'b0;
`endif

   logic unused_bits;
   assign unused_bits = &{1'b0, cpu.bus_wrdata[31:8], cpu.bus_wrdata[6:4], cpu.bus_wrdata[1:0],
                          cts_sync_reg[1], wr_ctrl};

   // ---------------- TX FIFO and shifter ----------------
   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
   logic [1:0]    tx_state_reg;
   logic [15:0]   tx_cnt_reg;
   logic [2:0]    tx_bit_reg;
   logic [7:0]    tx_shift_reg;
   logic          txd_reg, tx_full, tx_empty, tx_push, tx_pop, tx_busy;

   assign tx_full  = (tx_count_reg == FULL_CNT);
   assign tx_empty = (tx_count_reg == '0);
   // A new frame may start from IDLE or straight out of the last stop-bit clock.
   assign tx_pop   = !tx_empty && cts_ok &&
                     ((tx_state_reg == IDLE) || ((tx_state_reg == STOP) && (tx_cnt_reg == BIT_END)));
   assign tx_push  = wr_data && (!tx_full || tx_pop);
   assign tx_busy  = !tx_empty || (tx_state_reg != IDLE);

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr_reg] <= cpu.bus_wrdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         tx_wr_ptr_reg <= '0;
         tx_rd_ptr_reg <= '0;
         tx_count_reg  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + AW'(1);
         if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + AW'(1);
         tx_count_reg <= tx_count_reg + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         tx_state_reg <= IDLE;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= '0;
         tx_shift_reg <= '0;
         txd_reg      <= 1'b1;
      end else if (tx_pop) begin
         tx_state_reg <= START;
         tx_cnt_reg   <= '0;
         tx_shift_reg <= tx_mem[tx_rd_ptr_reg];
         txd_reg      <= 1'b0;
      end else if (tx_state_reg == IDLE) begin
         tx_cnt_reg <= '0;
      end else if (tx_cnt_reg != BIT_END) begin
         tx_cnt_reg <= tx_cnt_reg + 16'd1;
      end else begin
         tx_cnt_reg <= '0;
         case (tx_state_reg)
            START: begin
               tx_state_reg <= DATA;
               tx_bit_reg   <= '0;
               txd_reg      <= tx_shift_reg[0];
               tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            end
            DATA: begin
               if (tx_bit_reg == 3'd7) begin
                  tx_state_reg <= STOP;
                  txd_reg      <= 1'b1;
               end else begin
                  tx_bit_reg   <= tx_bit_reg + 3'd1;
                  txd_reg      <= tx_shift_reg[0];
                  tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
               end
            end
            default: tx_state_reg <= IDLE;
         endcase
      end
   end
   assign uart_txd = txd_reg;

   // ---------------- RX sampler and FIFO ----------------
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
   logic [1:0]    rx_state_reg;
   logic [15:0]   rx_cnt_reg;
   logic [2:0]    rx_bit_reg;
   logic [7:0]    rx_shift_reg;
   logic          rx_full, rx_empty, rx_done, rx_push, rx_pop, ovf_set, fe_set;
   logic          ovf_reg, fe_reg;

   assign rx_full  = (rx_count_reg == FULL_CNT);
   assign rx_empty = (rx_count_reg == '0);
   assign rx_done  = (rx_state_reg == STOP) && (rx_cnt_reg == BIT_END);
   assign fe_set   = rx_done && !rxd_s;
   assign rx_pop   = rd_data && !rx_empty;
   assign rx_push  = rx_done && rxd_s && (!rx_full || rx_pop);
   assign ovf_set  = rx_done && rxd_s && rx_full && !rx_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_reg <= IDLE;
         rx_cnt_reg   <= '0;
         rx_bit_reg   <= '0;
         rx_shift_reg <= '0;
      end else begin
         case (rx_state_reg)
            IDLE: begin
               rx_cnt_reg <= '0;
               if (rxd_prev_reg && !rxd_s) rx_state_reg <= START;
            end
            START: begin
               if (rx_cnt_reg == HALF_END) begin
                  rx_cnt_reg   <= '0;
                  rx_bit_reg   <= '0;
                  rx_state_reg <= rxd_s ? IDLE : DATA;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + 16'd1;
               end
            end
            DATA: begin
               if (rx_cnt_reg == BIT_END) begin
                  rx_cnt_reg   <= '0;
                  rx_shift_reg <= {rxd_s, rx_shift_reg[7:1]};
                  rx_bit_reg   <= rx_bit_reg + 3'd1;
                  if (rx_bit_reg == 3'd7) rx_state_reg <= STOP;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + 16'd1;
               end
            end
            default: begin
               if (rx_cnt_reg == BIT_END) begin
                  rx_cnt_reg   <= '0;
                  rx_state_reg <= IDLE;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + 16'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_shift_reg;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rx_wr_ptr_reg <= '0;
         rx_rd_ptr_reg <= '0;
         rx_count_reg  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + AW'(1);
         if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + AW'(1);
         rx_count_reg <= rx_count_reg + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      end
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_reg <= 1'b0;
         fe_reg  <= 1'b0;
      end else begin
         ovf_reg <= ovf_set || (ovf_reg && !clr_ovf);
         fe_reg  <= fe_set || (fe_reg && !clr_fe);
      end
   end

   logic [31:0] rddata_reg;
   always_ff @(posedge clk) begin
      if (reset) begin
         rddata_reg <= '0;
      end else if (cpu.bus_rden) begin
         case (cpu.bus_addr)
            2'd0:    rddata_reg <= {27'd0, tx_full, fe_reg, ovf_reg, tx_busy, !rx_empty};
            2'd1:    rddata_reg <= rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_ptr_reg]};
            2'd2:    rddata_reg <= {31'd0, ctrl_flow};
            default: rddata_reg <= '0;
         endcase
      end
   end
   assign cpu.bus_rddata = rddata_reg;
endmodule

// File: doc/esp_uart.md
ESP_UART -- requirements
Module: esp_uart

Interface
REQ-001 Parameter: BAUD_DIV, default 25, clocks per UART bit (legal range 4..65535).
REQ-002 Parameter: FIFO_DEPTH, default 16, entries per RX and TX FIFO (power of two, 4..256).
REQ-003 Port: clk  in  1  system clock; all logic on rising edge.
REQ-004 Port: reset  in  1  synchronous active-high reset.
REQ-005 Port: bus_addr  in  2  word index: 0=STATUS, 1=DATA, 2=CTRL, 3=reserved.
REQ-006 Port: bus_wrdata  in  32  write data.
REQ-007 Port: bus_wren  in  1  write strobe, one cycle per access.
REQ-008 Port: bus_rden  in  1  read strobe, one cycle per access.
REQ-009 Port: bus_rddata  out  32  registered read data.
REQ-010 Port: uart_txd  out  1  serial output, idle high.
REQ-011 Port: uart_rxd  in  1  asynchronous serial input.
REQ-012 Port: uart_cts_n  in  1  asynchronous clear-to-send, active low.
REQ-013 Port: uart_rts_n  out  1  ready-to-receive, active low.

Function
REQ-014 Frame format SHALL be 8N1, LSB first, each bit BAUD_DIV clocks.
REQ-015 bus_rddata SHALL be valid the cycle after bus_rden, hold until the next read, and be 0 for reserved address or unused bits.
REQ-016 STATUS read SHALL return: bit0 RX FIFO non-empty; bit1 TX busy (TX FIFO non-empty or shifter active); bit2 RX overflow (sticky); bit3 framing error (sticky); bit4 TX FIFO full.
REQ-017 STATUS write: bit2=1 or bit3=1 clears that flag; bit7=1 flushes both FIFOs and aborts the TX shifter (uart_txd high next cycle); other bits ignored.
REQ-018 DATA write SHALL push bus_wrdata[7:0] into TX FIFO; when full the byte is dropped, no flag set.
REQ-019 DATA read SHALL return RX FIFO head in bits[7:0] and pop it; when empty it returns 0 and pops nothing.
REQ-020 CTRL bit0 SHALL be the hardware-flow-control enable, read/write.
REQ-021 TX state machine SHALL use states IDLE, START, DATA, STOP; IDLE->START when TX FIFO non-empty (and CTS permits), popping the byte on that transition; STOP->IDLE after one bit time; back-to-back frames allowed with no extra idle bit.
REQ-022 uart_rxd and uart_cts_n SHALL pass a 2-flop synchronizer before use.
REQ-023 RX state machine SHALL use states IDLE, START, DATA, STOP; start on synchronized falling edge; re-check at BAUD_DIV/2, return to IDLE if high (glitch); sample each data bit mid-bit.
REQ-024 At STOP mid-bit: if stop bit low, set framing error and discard byte; else push byte, and if RX FIFO full, discard byte and set overflow.
REQ-025 Simultaneous push and pop on a FIFO in one cycle SHALL both occur, including when full or empty-with-push; count unchanged when both succeed.
REQ-026 Flush coincident with push SHALL leave the FIFO empty.
REQ-027 Clearing a sticky flag in the same cycle it is set SHALL leave it set.

Reset
REQ-028 On reset: FIFOs empty, both state machines IDLE, uart_txd=1, uart_rts_n=1 only if flow control enabled else 0, status flags 0, CTRL=0, bus_rddata=0.
REQ-029 Reset mid-frame SHALL abort the frame; uart_txd high the cycle after reset asserted; partial RX byte discarded.

Configuration
REQ-030 Macro ESP_UART_HWFLOW_EN defined: when CTRL bit0=1, TX does not leave IDLE while synchronized uart_cts_n=1 (frame in progress completes); uart_rts_n=1 when RX FIFO has fewer than 2 free entries, else 0.
REQ-031 Macro ESP_UART_HWFLOW_EN undefined: CTRL bit0 reads 0 and ignores writes, uart_cts_n ignored, uart_rts_n constant 0.

Verification
REQ-032 Write DATA=0x41, BAUD_DIV=25 -> uart_txd low 25 clocks, then 1,0,0,0,0,0,1,0 each 25 clocks, then high; STATUS bit1 clears after stop bit.
REQ-033 Drive 0x5A frame on uart_rxd -> STATUS bit0=1; DATA read returns 0x5A; next STATUS bit0=0; DATA read on empty returns 0.
REQ-034 Send FIFO_DEPTH+1 frames without reading -> STATUS bit2=1, first FIFO_DEPTH bytes intact; write STATUS=0x04 -> bit2=0.
REQ-035 Frame with stop bit low -> STATUS bit3=1, no byte pushed; 0.3-bit low glitch on rxd -> no byte, no flag.
REQ-036 With ESP_UART_HWFLOW_EN, CTRL=1, cts_n=1, write two bytes -> txd stays high; cts_n=0 -> both frames sent back-to-back.
REQ-037 Write STATUS=0x83 mid-transmission with 3 bytes queued -> txd high next cycle, STATUS bit1=0, bit0=0.
